// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        StInit,
        StReady
    } rf_state_e;

    function automatic int unsigned aw_from_nregs(input int unsigned nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-writeback bits, one per register; a same-cycle issue beats a clearing write.
module regfile_scoreboard #(
    parameter int unsigned NREGS = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NREGS-1:0] set_i,
    input  logic [NREGS-1:0] clr_i,
    output logic [NREGS-1:0] busy_o
);

    logic [NREGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = (busy_q & ~clr_i) | set_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass, pending-writeback scoreboard
// and a post-reset clear sequencer so the storage array itself carries no reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = aw_from_nregs(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                init_done,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr
);

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             init_done_q, init_done_d;

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];

    logic [AW-1:0]    wa [NWR];
    logic [XLEN-1:0]  wd [NWR];
    logic [NWR-1:0]   wr_ok;
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] iss_set;
    logic [NREGS-1:0] busy;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {AW{1'b1}}) begin
                    state_d     = StReady;
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            StReady: ;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done = init_done_q;

    // Writes are only honoured once the clear sequence is done; x0 is dropped with ZERO_REG.
    always_comb begin
        wr_ok = '0;
        for (int unsigned p = 0; p < NWR; p++) begin
            wa[p]    = wr_addr[p*AW +: AW];
            wd[p]    = wr_data[p*XLEN +: XLEN];
            wr_ok[p] = init_done_q && wr_en[p] && !(ZERO_REG && (wa[p] == '0));
        end
    end

    // Ascending port loop lets the highest-index writer win each entry.
    always_comb begin
        mem_d  = mem_q;
        wr_hit = '0;
        if (!init_done_q) begin
            mem_d[cnt_q] = '0;
        end else begin
            for (int unsigned p = 0; p < NWR; p++) begin
                if (wr_ok[p]) begin
                    mem_d[wa[p]]  = wd[p];
                    wr_hit[wa[p]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        iss_set = '0;
        if (init_done_q && iss_en && !(ZERO_REG && (iss_addr == '0))) begin
            iss_set[iss_addr] = 1'b1;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .set_i  (iss_set),
        .clr_i  (wr_hit),
        .busy_o (busy)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            logic [AW-1:0]   a;
            logic            hit;
            logic [XLEN-1:0] byp;
            a   = rd_addr[i*AW +: AW];
            hit = 1'b0;
            byp = '0;
            for (int unsigned p = 0; p < NWR; p++) begin
                if (wr_ok[p] && (wa[p] == a)) begin
                    hit = 1'b1;
                    byp = wd[p];
                end
            end
            if (init_done_q && !(ZERO_REG && (a == '0))) begin
                rd_data[i*XLEN +: XLEN] = hit ? byp : mem_q[a];
                rd_busy[i]              = busy[a] & ~hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expected read results are queued when stimulus is driven
// and popped/compared just after the inputs settle.
module tb_regfile_mp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             init_done;
    logic [2*AW-1:0]  rd_addr;
    logic [63:0]      rd_data;
    logic [1:0]       rd_busy;
    logic [1:0]       wr_en;
    logic [2*AW-1:0]  wr_addr;
    logic [63:0]      wr_data;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        string       tag;
        int unsigned port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t expq[$];

    regfile_mp #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NRD      (2),
        .NWR      (2),
        .ZERO_REG (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr)
    );

    always #5 clk = ~clk;

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
    endtask

    task automatic set_wr(input int unsigned p, input logic en, input int unsigned addr,
                          input logic [31:0] d);
        wr_en[p]             = en;
        wr_addr[p*AW +: AW]  = AW'(addr);
        wr_data[p*32 +: 32]  = d;
    endtask

    task automatic issue(input int unsigned addr);
        iss_en   = 1'b1;
        iss_addr = AW'(addr);
    endtask

    task automatic expect_rd(input string tag, input int unsigned port, input int unsigned addr,
                             input logic [31:0] d, input logic b);
        exp_t e;
        rd_addr[port*AW +: AW] = AW'(addr);
        e.tag  = tag;
        e.port = port;
        e.data = d;
        e.busy = b;
        expq.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [31:0] obs_d;
        logic        obs_b;
        #1;
        while (expq.size() > 0) begin
            e     = expq.pop_front();
            obs_d = rd_data[e.port*32 +: 32];
            obs_b = rd_busy[e.port];
            checks++;
            assert (obs_d === e.data) else begin
                errors++;
                $error("FAIL %s data port%0d: got %h expected %h", e.tag, e.port, obs_d, e.data);
            end
            checks++;
            assert (obs_b === e.busy) else begin
                errors++;
                $error("FAIL %s busy port%0d: got %b expected %b", e.tag, e.port, obs_b, e.busy);
            end
        end
    endtask

    task automatic chk_done(input string tag, input logic exp_v);
        checks++;
        assert (init_done === exp_v) else begin
            errors++;
            $error("FAIL %s init_done: got %b expected %b", tag, init_done, exp_v);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rd_addr = '0;
        idle();

        // Held in reset
        @(negedge clk);
        @(negedge clk);
        chk_done("rst", 1'b0);
        expect_rd("rst", 0, 5, 32'h0, 1'b0);
        expect_rd("rst", 1, 9, 32'h0, 1'b0);
        check_out();

        // Release, then pulse reset at INIT cycle 10
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            chk_done("init_early", 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_done("init_pulse", 1'b0);

        // Release again with a write and issue that INIT must ignore
        @(negedge clk);
        rst_n = 1'b1;
        set_wr(0, 1'b1, 3, 32'h55);
        issue(3);
        expect_rd("init_rd", 0, 3, 32'h0, 1'b0);
        check_out();
        for (int k = 1; k <= int'(NREGS); k++) begin
            @(negedge clk);
            if (k == 1) idle();
            if (k >= int'(NREGS) - 1) chk_done("init_count", (k == int'(NREGS)));
        end

        // Every register cleared and idle
        for (int r = 0; r < int'(NREGS); r++) begin
            expect_rd("clear", 0, r, 32'h0, 1'b0);
            expect_rd("clear", 1, NREGS - 1 - r, 32'h0, 1'b0);
            check_out();
        end

        @(negedge clk); idle();
        set_wr(0, 1'b1, 5, 32'hDEAD_BEEF);
        expect_rd("x5_bypass", 0, 5, 32'hDEAD_BEEF, 1'b0);
        expect_rd("x7_init", 1, 7, 32'h0, 1'b0);
        check_out();

        @(negedge clk); idle();
        expect_rd("x5_stored", 0, 5, 32'hDEAD_BEEF, 1'b0);
        check_out();

        @(negedge clk); idle();
        set_wr(0, 1'b1, 7, 32'h1111_1111);
        set_wr(1, 1'b1, 7, 32'h2222_2222);
        expect_rd("x7_prio_byp", 0, 7, 32'h2222_2222, 1'b0);
        expect_rd("x5_other", 1, 5, 32'hDEAD_BEEF, 1'b0);
        check_out();

        @(negedge clk); idle();
        expect_rd("x7_prio_st", 0, 7, 32'h2222_2222, 1'b0);
        check_out();

        @(negedge clk); idle();
        set_wr(1, 1'b1, 0, 32'hFFFF_FFFF);
        issue(0);
        expect_rd("x0_byp", 0, 0, 32'h0, 1'b0);
        expect_rd("x0_byp", 1, 0, 32'h0, 1'b0);
        check_out();

        @(negedge clk); idle();
        expect_rd("x0_after", 0, 0, 32'h0, 1'b0);
        check_out();

        @(negedge clk); idle();
        issue(9);
        expect_rd("x9_iss_same", 0, 9, 32'h0, 1'b0);
        check_out();

        @(negedge clk); idle();
        expect_rd("x9_busy", 0, 9, 32'h0, 1'b1);
        expect_rd("x9_busy", 1, 9, 32'h0, 1'b1);
        check_out();

        @(negedge clk); idle();
        set_wr(0, 1'b1, 9, 32'h42);
        expect_rd("x9_wb", 0, 9, 32'h42, 1'b0);
        check_out();

        @(negedge clk); idle();
        expect_rd("x9_wb_after", 0, 9, 32'h42, 1'b0);
        check_out();

        @(negedge clk); idle();
        issue(9);
        set_wr(1, 1'b1, 9, 32'h43);
        expect_rd("x9_iss_wr", 0, 9, 32'h43, 1'b0);
        check_out();

        @(negedge clk); idle();
        expect_rd("x9_iss_wins", 0, 9, 32'h43, 1'b1);
        check_out();

        @(negedge clk); idle();
        set_wr(0, 1'b1, 10, 32'hA);
        set_wr(1, 1'b1, 11, 32'hB);
        expect_rd("split_byp", 0, 10, 32'hA, 1'b0);
        expect_rd("split_byp", 1, 11, 32'hB, 1'b0);
        check_out();

        @(negedge clk); idle();
        set_wr(0, 1'b1, 7, 32'h33);
        set_wr(1, 1'b0, 7, 32'h44);
        expect_rd("x7_p1_off", 0, 7, 32'h33, 1'b0);
        expect_rd("split_st", 1, 10, 32'hA, 1'b0);
        check_out();

        @(negedge clk); idle();
        expect_rd("x7_p1_off_st", 0, 7, 32'h33, 1'b0);
        expect_rd("split_st", 1, 11, 32'hB, 1'b0);
        check_out();

        // Reset mid-READY clears scoreboard and restarts the clear sequence
        @(negedge clk); idle();
        rst_n = 1'b0;
        expect_rd("rst_ready", 0, 9, 32'h0, 1'b0);
        check_out();
        chk_done("rst_ready", 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= int'(NREGS); k++) begin
            @(negedge clk);
            if (k >= int'(NREGS) - 1) chk_done("reinit_count", (k == int'(NREGS)));
        end
        expect_rd("reinit_x9", 0, 9, 32'h0, 1'b0);
        expect_rd("reinit_x5", 1, 5, 32'h0, 1'b0);
        check_out();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the ID stage of the pipelined RISC-V core; successor of the single-write, two-read register file. Adds configurable width/depth/port count, same-cycle write-to-read bypass, a per-register pending-writeback scoreboard for hazard detection, and a post-reset clear sequencer so the storage array needs no per-entry reset.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥4)
- NRD, 2, number of read ports
- NWR, 2, number of write ports; higher index = higher priority
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never busy

Ports (AW = log2(NREGS)):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- init_done  out  1  high once clear sequence has finished
- rd_addr  in  NRD*AW  read addresses, port i in slice i
- rd_data  out  NRD*XLEN  read data, combinational
- rd_busy  out  NRD  pending-writeback flag for each read address
- wr_en  in  NWR  write enables
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- iss_en  in  1  mark iss_addr as pending writeback
- iss_addr  in  AW  destination register being issued

## Operation
- FSM: INIT → READY. rst_n low forces INIT, clear counter = 0, all scoreboard bits = 0, init_done = 0.
- INIT: one entry written with 0 per cycle, counter 0..NREGS-1; after the write of entry NREGS-1 → READY. wr_en and iss_en ignored; rd_data = 0, rd_busy = 0.
- READY: init_done = 1; stays until reset.
- Write: for each entry, the highest-index port with wr_en and a matching address writes it at posedge; lower ports to the same address are dropped. Address 0 is discarded when ZERO_REG = 1.
- Read (per port): address 0 with ZERO_REG → 0. Otherwise, if any write port hits the address this cycle, return the highest-priority write data (bypass); else return stored value.
- Scoreboard: bit set at posedge when iss_en hits the address; cleared at posedge when any write hits it. Issue and write to the same address in one cycle → bit ends set (issue wins).
- rd_busy(i) = scoreboard bit AND NOT (write hit this cycle). A same-cycle issue does not affect rd_busy until the next cycle.
- No width conversion; data is stored verbatim.

## Timing
- Read latency 0 (combinational from rd_addr, wr_*, state).
- Write visible via bypass in the same cycle and from storage the cycle after.
- Issue visible on rd_busy one cycle after iss_en.
- Clear sequence takes exactly NREGS cycles after rst_n deasserts; init_done rises on the edge ending the last clear write.
- Reset values: init_done 0, rd_data 0, rd_busy 0. Reset asserted mid-INIT or mid-READY restarts INIT from entry 0 and clears the scoreboard; contents are undefined until the clear completes.

## Structure
- Package regfile_pkg: state enum {INIT, READY} and an AW-from-NREGS helper function.
- Sub-module regfile_scoreboard: NREGS set/clear bits with issue-wins priority, async reset; the top level holds the storage array, clear counter/FSM, write priority and bypass muxes.

## Test plan
- Reset, then idle for NREGS cycles → init_done rises at cycle NREGS; each register reads 0x0000_0000 with busy 0.
- wr_en[0] to x5 = 0xDEAD_BEEF, rd_addr[0] = 5 in the same cycle → rd_data = 0xDEAD_BEEF; the next cycle with no write still reads 0xDEAD_BEEF.
- Both ports write x7 (port0 0x1111_1111, port1 0x2222_2222) → bypass and stored value both 0x2222_2222.
- Write x0 = 0xFFFF_FFFF and issue x0 → x0 reads 0, rd_busy 0.
- Issue x9 → rd_busy 1 next cycle; write x9 = 0x42 → rd_busy 0 that cycle, value 0x42; issue and write x9 together → busy 1 afterwards.
- Write x3 = 0x55 during INIT → ignored (x3 = 0 after init); pulse rst_n low at INIT cycle 10 → init_done delayed to NREGS cycles after release.
